// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
`ifndef NUM_REGISTERS_LOG2
`define NUM_REGISTERS_LOG2 5
`endif

package pipeline_hazard_ctrl_pkg;

    // Register index width of the register file
    localparam int unsigned NUM_REG_ADDR_W = `NUM_REGISTERS_LOG2;

    // Register 0 is hard-wired to zero and never creates a dependency
    localparam int unsigned REG_ZERO = 0;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2,
        ST_REDIRECT   = 2'd3
    } state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the debug event counters.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Increment on request, holding at all-ones instead of wrapping
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer: load-use stalls, branch redirects and
// data-memory freezes for the 5-stage pipeline.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W  = NUM_REG_ADDR_W,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_to_reg,
    input  logic [REG_ADDR_W-1:0] ex_reg_dst,
    input  logic                  mem_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  pc_redirect,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_stall,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic                  pipe_freeze,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events,
    output logic                  mem_timeout
);

    // Wait counter is wide enough to exceed MEM_TIMEOUT before it saturates
    localparam int unsigned       WAIT_W   = $clog2(MEM_TIMEOUT + 2);
    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

    state_e            state_q;
    state_e            state_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;
    logic              timeout_q;
    logic              timeout_d;

    logic hazard;
    logic freeze;
    logic redirect;
    logic load_use;

    // Load in EX feeding a source of the instruction in ID
    assign hazard = ex_mem_to_reg
                  && (ex_reg_dst != REG_ADDR_W'(REG_ZERO))
                  && ((ex_reg_dst == id_rs) || (id_uses_rt && (ex_reg_dst == id_rt)));

    // Event priority: freeze > redirect > load-use (load-use only from RUN)
    assign freeze   = mem_req && !mem_ready;
    assign redirect = !freeze && mem_branch_taken;
    assign load_use = !freeze && !redirect && (state_q == ST_RUN) && hazard;

    // Next state and control outputs; reset forces the flush-everything pattern
    always_comb begin
        state_d      = ST_RUN;
        pc_write     = 1'b0;
        pc_redirect  = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pipe_freeze  = 1'b0;

        if (reset) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (freeze) begin
            pipe_freeze = 1'b1;
            state_d     = ST_MEM_WAIT;
        end else if (redirect) begin
            pc_redirect  = 1'b1;
            pc_write     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_d      = ST_REDIRECT;
        end else if (load_use) begin
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
            state_d     = ST_LOAD_STALL;
        end else begin
            pc_write = 1'b1;
        end
    end

    // Consecutive-freeze counter and sticky timeout flag
    always_comb begin
        wait_cnt_d = '0;
        if (freeze) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : (wait_cnt_q + WAIT_W'(1));
        end
        timeout_d = timeout_q || (32'(wait_cnt_d) > MEM_TIMEOUT);
    end

    // State, wait counter and timeout registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign mem_timeout = timeout_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (pipe_freeze || if_id_stall),
        .count (stall_cycles)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (pc_redirect),
        .count (flush_events)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed cases then random traffic
// checked against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned CNT_W       = 3;
    localparam int unsigned MEM_TIMEOUT = 5;
    localparam int          CNT_MAX     = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [7:0]       ctrl;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
        logic             tmo;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [REG_ADDR_W-1:0] id_rs = '0;
    logic [REG_ADDR_W-1:0] id_rt = '0;
    logic                  id_uses_rt = 1'b0;
    logic                  ex_mem_to_reg = 1'b0;
    logic [REG_ADDR_W-1:0] ex_reg_dst = '0;
    logic                  mem_branch_taken = 1'b0;
    logic                  mem_req = 1'b0;
    logic                  mem_ready = 1'b0;
    logic                  pc_write, pc_redirect, if_id_stall, if_id_flush;
    logic                  id_ex_stall, id_ex_flush, ex_mem_flush, pipe_freeze;
    logic [CNT_W-1:0]      stall_cycles, flush_events;
    logic                  mem_timeout;

    int errors = 0;
    int checks = 0;
    exp_t exp_q[$];

    // Model: counts, consecutive freeze length, and what the previous cycle did
    int m_stall = 0;
    int m_flush = 0;
    int m_wait  = 0;
    bit m_tmo   = 1'b0;
    bit m_prev_redirect = 1'b0;
    bit m_prev_loaduse  = 1'b0;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W  (REG_ADDR_W),
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_uses_rt       (id_uses_rt),
        .ex_mem_to_reg    (ex_mem_to_reg),
        .ex_reg_dst       (ex_reg_dst),
        .mem_branch_taken (mem_branch_taken),
        .mem_req          (mem_req),
        .mem_ready        (mem_ready),
        .pc_write         (pc_write),
        .pc_redirect      (pc_redirect),
        .if_id_stall      (if_id_stall),
        .if_id_flush      (if_id_flush),
        .id_ex_stall      (id_ex_stall),
        .id_ex_flush      (id_ex_flush),
        .ex_mem_flush     (ex_mem_flush),
        .pipe_freeze      (pipe_freeze),
        .stall_cycles     (stall_cycles),
        .flush_events     (flush_events),
        .mem_timeout      (mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ctrl", 32'({pc_write, pc_redirect, if_id_stall, if_id_flush,
                                 id_ex_stall, id_ex_flush, ex_mem_flush, pipe_freeze}), 32'(e.ctrl));
                chk("stall_cycles", 32'(stall_cycles), 32'(e.stall));
                chk("flush_events", 32'(flush_events), 32'(e.flush));
                chk("mem_timeout",  32'(mem_timeout),  32'(e.tmo));
            end
        end
    end

    // Drive one cycle of inputs, predict the response, advance the model
    task automatic step(input logic rst,
                        input logic [REG_ADDR_W-1:0] rs, input logic [REG_ADDR_W-1:0] rt,
                        input logic urt, input logic m2r, input logic [REG_ADDR_W-1:0] dst,
                        input logic br, input logic req, input logic rdy);
        exp_t e;
        bit fz, rd, lu, haz, in_run;
        @(posedge clk);
        #1;
        reset = rst; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_mem_to_reg = m2r;
        ex_reg_dst = dst; mem_branch_taken = br; mem_req = req; mem_ready = rdy;
        if (rst) begin
            m_stall = 0; m_flush = 0; m_wait = 0; m_tmo = 1'b0;
            m_prev_redirect = 1'b0; m_prev_loaduse = 1'b0;
            e.ctrl  = 8'b0001_0110;
            e.stall = '0;
            e.flush = '0;
            e.tmo   = 1'b0;
            exp_q.push_back(e);
        end else begin
            fz     = req && !rdy;
            rd     = !fz && br;
            in_run = !m_prev_redirect && !m_prev_loaduse && (m_wait == 0);
            haz    = m2r && (dst != 0) && ((dst == rs) || (urt && (dst == rt)));
            lu     = !fz && !rd && in_run && haz;
            if (fz)      e.ctrl = 8'b0000_0001;
            else if (rd) e.ctrl = 8'b1101_0110;
            else if (lu) e.ctrl = 8'b0010_1000;
            else         e.ctrl = 8'b1000_0000;
            e.stall = CNT_W'(m_stall);
            e.flush = CNT_W'(m_flush);
            e.tmo   = m_tmo;
            exp_q.push_back(e);
            if ((fz || lu) && m_stall < CNT_MAX) m_stall++;
            if (rd && m_flush < CNT_MAX) m_flush++;
            m_wait = fz ? m_wait + 1 : 0;
            if (m_wait > MEM_TIMEOUT) m_tmo = 1'b1;
            m_prev_redirect = rd;
            m_prev_loaduse  = lu;
        end
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic freeze_cyc(input logic br);
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, br, 1'b1, 1'b0);
    endtask

    initial begin
        int budget;
        // Reset
        step(1'b1, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        idle();
        // Load-use on rs, then held inputs in LOAD_STALL flow normally
        step(1'b0, 5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
        idle();
        // Load-use on rt only when rt is used
        step(1'b0, 5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        idle();
        // Load to r0 never stalls
        step(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        // Branch with load-use: redirect wins, next cycle load-use suppressed
        step(1'b0, 5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        step(1'b0, 5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
        idle();
        // Freeze 4 cycles then ready
        repeat (4) freeze_cyc(1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        idle();
        // Long freeze trips the sticky timeout
        repeat (9) freeze_cyc(1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        idle();
        idle();
        // Freeze with a pending branch: branch taken on release
        repeat (2) freeze_cyc(1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        idle();
        // Redirect burst saturates flush_events
        repeat (10) step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle();
        // Reset asserted mid-wait
        repeat (3) freeze_cyc(1'b0);
        step(1'b1, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle();
        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 299) == 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 99) < 15),
                 1'($urandom_range(0, 99) < 30),
                 1'($urandom_range(0, 99) < 45));
        end
        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers). Detects load-use hazards, redirects on branches resolved in MEM, and freezes the pipeline while data memory is busy. Drives the stall/flush inputs of the pipeline registers and the PC write enable. Keeps saturating event counters and a sticky memory-timeout flag for debug.

Parameters:
REG_ADDR_W, 5, register index width (= `NUM_REGISTERS_LOG2).
CNT_W, 16, width of each performance counter.
MEM_TIMEOUT, 255, maximum consecutive MEM_WAIT cycles before mem_timeout is set.

Ports:
clk  in  1  pipeline clock, rising edge.
reset  in  1  asynchronous, active-high reset.
id_rs  in  REG_ADDR_W  source register 1 of the instruction in ID.
id_rt  in  REG_ADDR_W  source register 2 of the instruction in ID.
id_uses_rt  in  1  ID instruction reads rt as a source.
ex_mem_to_reg  in  1  instruction in EX is a load.
ex_reg_dst  in  REG_ADDR_W  destination register of the EX instruction.
mem_branch_taken  in  1  (beq & compare) | (bne & !compare) from EX/MEM.
mem_req  in  1  MEM stage is accessing data memory this cycle.
mem_ready  in  1  data memory completes the access this cycle.
pc_write  out  1  PC update enable.
pc_redirect  out  1  select branch target as the next PC.
if_id_stall  out  1  hold IF/ID.
if_id_flush  out  1  zero IF/ID.
id_ex_stall  out  1  insert a bubble into ID/EX (the register zeroes itself).
id_ex_flush  out  1  zero ID/EX.
ex_mem_flush  out  1  zero EX/MEM.
pipe_freeze  out  1  hold every pipeline register and the PC.
stall_cycles  out  CNT_W  number of cycles with load-use or freeze active; saturating.
flush_events  out  CNT_W  number of redirects; saturating.
mem_timeout  out  1  sticky: MEM_WAIT lasted more than MEM_TIMEOUT cycles.

Behaviour:
- FSM states: RUN, LOAD_STALL, MEM_WAIT, REDIRECT. Reset puts the FSM in RUN and clears both counters, the wait counter, and mem_timeout.
- While reset is high:
  - pc_write=0, pc_redirect=0, all stalls=0, pipe_freeze=0.
  - if_id_flush, id_ex_flush, ex_mem_flush = 1.
- Outputs are combinational from the current state and inputs. State and counters update on the rising edge of clk.
- Event priority, highest first: freeze > redirect > load-use.
- Freeze:
  - Condition: mem_req & !mem_ready, in any state.
  - Outputs: pipe_freeze=1, pc_write=0, all flushes=0.
  - Next state is MEM_WAIT; the wait counter increments.
  - In MEM_WAIT, mem_ready=1 releases the freeze in that same cycle, evaluates the other conditions normally, and clears the wait counter.
  - When the wait counter exceeds MEM_TIMEOUT, mem_timeout is set. The freeze continues; mem_timeout clears only on reset.
- Redirect:
  - Condition: mem_branch_taken, and not frozen.
  - Outputs: pc_redirect=1, pc_write=1, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1.
  - flush_events increments. Next state is REDIRECT.
- REDIRECT state lasts exactly one cycle:
  - Load-use detection is suppressed, because the ID contents are the first fetched target.
  - The branch input is still honoured.
  - Returns to RUN.
- Load-use:
  - Condition: ex_mem_to_reg & ex_reg_dst != 0 & (ex_reg_dst == id_rs | (id_uses_rt & ex_reg_dst == id_rt)), in RUN only.
  - Outputs: pc_write=0, if_id_stall=1, id_ex_stall=1.
  - Next state is LOAD_STALL.
- LOAD_STALL lasts one cycle with normal flow (the load has moved to MEM), then returns to RUN. A second load-use cannot be raised from LOAD_STALL.
- Default in RUN with no event: pc_write=1, all other control outputs 0.
- stall_cycles increments in every cycle where pipe_freeze or if_id_stall is 1.
- Both counters saturate at all-ones and never wrap.
- Simultaneous events:
  - Freeze and branch: freeze wins. The branch is taken on the cycle the freeze releases, because the EX/MEM contents are held.
  - Branch and load-use: redirect only; no stall.
- Reset asserted mid-operation, in any state: return immediately (asynchronously) to the reset outputs above.

Decomposition:
- Shared package: FSM state encoding (2 bits), register-0 constant, and REG_ADDR_W tied to `NUM_REGISTERS_LOG2.
- One sub-module: sat_counter (CNT_W, inc, clk, reset), instantiated twice.
- The hazard compare stays inline.

Test Plan:
- Load r3 in EX (ex_reg_dst=3, ex_mem_to_reg=1), id_rs=3 -> exactly one cycle of pc_write=0, if_id_stall=1, id_ex_stall=1; stall_cycles=1; FSM RUN→LOAD_STALL→RUN.
- Load to r0 with id_rs=0 -> no stall; pc_write=1.
- mem_branch_taken=1 with load-use also true -> pc_redirect and all three flushes=1 for one cycle, no stall; flush_events=1; next cycle has load-use suppressed.
- mem_req=1, mem_ready=0 for 4 cycles, then 1 -> pipe_freeze=1 for 4 cycles and drops in the ready cycle; stall_cycles=4; mem_timeout=0.
- MEM_TIMEOUT=3, mem_ready held 0 for 6 cycles -> mem_timeout rises on the cycle after the 4th wait cycle and stays high until reset.
- CNT_W=2 with 5 redirects -> flush_events saturates at 3; reset asserted mid-MEM_WAIT -> state RUN, counters 0, flushes=1 while reset is high.
